mavg_mc_sched: RTL and testbench

Multi-channel moving-average scheduler. It shares one accumulate/subtract datapath and one flop-based sample store between C independent sample sources. Each accepted sample updates only its own channel's 2^M-sample window. A round-robin arbiter grants one channel per cycle, and each result leaves on a single output stream tagged with its channel number. The block sits between the per-channel front-end capture logic and the downstream averaging consumers.

---
 rtl/mavg_pkg.sv | 24 ++
 rtl/mavg_mc_sched_rr_arb.sv | 45 ++++
 rtl/mavg_mc_sched.sv | 100 ++++++++++
 tb/tb_mavg_mc_sched.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared types and helpers for the multi-channel moving-average scheduler.
// The widths here describe the default configuration. The top-level parameters
// M and N must match MAVG_M and MAVG_N, because ctx_t and avg_of are built from them.
package mavg_pkg;

    localparam int MAVG_C = 4;
    localparam int MAVG_M = 2;
    localparam int MAVG_N = 16;
    localparam int CH_W   = $clog2(MAVG_C);
    localparam int SUM_W  = MAVG_M + MAVG_N;

    // Per-channel window state: next write slot, samples held, running sum
    typedef struct packed {
        logic [MAVG_M-1:0] wr_ptr;
        logic [MAVG_M:0]   fill;
        logic [SUM_W-1:0]  sum;
    } ctx_t;

    // Window average: divide by 2^M, truncating toward zero
    function automatic logic [MAVG_N-1:0] avg_of(input logic [SUM_W-1:0] sum);
        return sum[SUM_W-1:MAVG_M];
    endfunction

endpackage

// File: rtl/mavg_mc_sched_rr_arb.sv
// C-input round-robin arbiter. gnt is one-hot or zero over req & ~mask.
// The search starts one past the last channel that actually transferred.
module rr_arb #(
    parameter int C = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [C-1:0] req,
    input  logic [C-1:0] mask,
    input  logic         advance,
    output logic [C-1:0] gnt
);

    localparam int IW = (C > 1) ? $clog2(C) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] idx;
    logic          found;

    // Pick the first eligible requester at or after last_q+1
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < C; k++) begin
            idx = IW'((int'(last_q) + 1 + k) % C);
            if (!found && req[idx] && !mask[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Remember the granted channel only when the transfer really happened
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= IW'(C - 1);
        end else if (advance) begin
            for (int i = 0; i < C; i++) begin
                if (gnt[i]) last_q <= IW'(i);
            end
        end
    end

endmodule

// File: rtl/mavg_mc_sched.sv
// Multi-channel moving-average scheduler. One shared accumulate/subtract
// datapath serves C channels, each with its own 2^M-sample window in a flop store.
module mavg_mc_sched
    import mavg_pkg::*;
#(
    parameter int C = MAVG_C,
    parameter int M = MAVG_M,
    parameter int N = MAVG_N
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [C*N-1:0]       ch_sample,
    input  logic [C-1:0]         ch_valid,
    output logic [C-1:0]         ch_ready,
    input  logic [C-1:0]         ch_clr,
    output logic [N-1:0]         avg,
    output logic [$clog2(C)-1:0] avg_ch,
    output logic                 avg_valid
);

    localparam int          AW   = $clog2(C);
    localparam logic [M:0]  FULL = (M+1)'(2**M);

    ctx_t                  ctx_q   [C];
    logic [N-1:0]          store_q [C][2**M];

    logic [C-1:0]          gnt;
    logic                  xfer;
    logic [AW-1:0]         g_p0;
    logic [N-1:0]          smp_p0;
    logic [N-1:0]          old_p0;
    ctx_t                  cur_p0;
    logic                  full_p0;
    logic [SUM_W-1:0]      sum_p0;
    logic [M:0]            fill_p0;
    logic                  vld_p0;

    rr_arb #(.C(C)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (ch_valid),
        .mask    (ch_clr),
        .advance (xfer),
        .gnt     (gnt)
    );

    // Grant decode and shared window update for the granted channel
    always_comb begin
        ch_ready = rstn ? gnt : '0;
        xfer     = |ch_ready;
        g_p0     = '0;
        for (int i = 0; i < C; i++) begin
            if (ch_ready[i]) g_p0 = AW'(i);
        end
        smp_p0  = ch_sample[int'(g_p0)*N +: N];
        cur_p0  = ctx_q[g_p0];
        full_p0 = (cur_p0.fill == FULL);
        old_p0  = full_p0 ? store_q[g_p0][cur_p0.wr_ptr] : '0;
        sum_p0  = cur_p0.sum + SUM_W'(smp_p0) - SUM_W'(old_p0);
        fill_p0 = full_p0 ? cur_p0.fill : cur_p0.fill + 1'b1;
        vld_p0  = xfer && (fill_p0 == FULL);
    end

    // ---- stage p0 -> context / store registers ----
    // Clear wins over update. The store is not cleared, because fill gates every read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < C; i++) begin
                ctx_q[i] <= '0;
                for (int j = 0; j < 2**M; j++) store_q[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < C; i++) begin
                if (ch_clr[i]) begin
                    ctx_q[i] <= '0;
                end else if (ch_ready[i]) begin
                    ctx_q[i] <= '{wr_ptr: cur_p0.wr_ptr + 1'b1, fill: fill_p0, sum: sum_p0};
                end
            end
            if (xfer) store_q[g_p0][cur_p0.wr_ptr] <= smp_p0;
        end
    end

    // ---- stage p0 -> output register ----
    // Present the average whenever the updated window is full; hold it otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            avg_valid <= 1'b0;
            avg       <= '0;
            avg_ch    <= '0;
        end else begin
            avg_valid <= vld_p0;
            if (vld_p0) begin
                avg    <= avg_of(sum_p0);
                avg_ch <= g_p0;
            end
        end
    end

endmodule

// File: tb/tb_mavg_mc_sched.sv
// Directed bench for mavg_mc_sched (C=4, M=2, N=16): a vector table plus
// hand-written sequences for reset, contention and clear collisions.
module tb_mavg_mc_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] ch_sample;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_clr;
    logic [15:0] avg;
    logic [1:0]  avg_ch;
    logic        avg_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  clr;
        logic [63:0] smp;
        logic [3:0]  rdy;
        logic        vld;
        logic [15:0] avg;
        logic [1:0]  ch;
        string       name;
    } vec_t;

    vec_t vecs[$];

    mavg_mc_sched #(.C(4), .M(2), .N(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ch_sample (ch_sample),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_clr    (ch_clr),
        .avg       (avg),
        .avg_ch    (avg_ch),
        .avg_valid (avg_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] clr,
                                input logic [63:0] smp, input logic [3:0] rdy,
                                input logic vld, input int a, input int ch, input string name);
        vec_t v;
        v.valid = valid; v.clr = clr; v.smp = smp; v.rdy = rdy;
        v.vld = vld; v.avg = 16'(a); v.ch = 2'(ch); v.name = name;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check ready before the edge, outputs after it
    task automatic cycle(input vec_t v);
        @(negedge clk);
        ch_valid  = v.valid;
        ch_clr    = v.clr;
        ch_sample = v.smp;
        #1;
        chk({v.name, " ch_ready"}, 32'(ch_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk({v.name, " avg_valid"}, 32'(avg_valid), 32'(v.vld));
        if (v.vld) begin
            chk({v.name, " avg"}, 32'(avg), 32'(v.avg));
            chk({v.name, " avg_ch"}, 32'(avg_ch), 32'(v.ch));
        end
    endtask

    initial begin
        // single channel 0: 10,20,30,40,50
        vecs.push_back(mk(4'b0001, 4'b0000, pk(10, 0, 0, 0), 4'b0001, 0, 0, 0, "single s1"));
        vecs.push_back(mk(4'b0001, 4'b0000, pk(20, 0, 0, 0), 4'b0001, 0, 0, 0, "single s2"));
        vecs.push_back(mk(4'b0001, 4'b0000, pk(30, 0, 0, 0), 4'b0001, 0, 0, 0, "single s3"));
        vecs.push_back(mk(4'b0001, 4'b0000, pk(40, 0, 0, 0), 4'b0001, 1, 25, 0, "single s4"));
        vecs.push_back(mk(4'b0001, 4'b0000, pk(50, 0, 0, 0), 4'b0001, 1, 35, 0, "single s5"));
        // interleaved channel 1 (4,8,12,16) and channel 2 (0xFFFF x4)
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 4, 65535, 0),  4'b0010, 0, 0, 0, "ilv r1"));
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 8, 65535, 0),  4'b0100, 0, 0, 0, "ilv r2"));
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 8, 65535, 0),  4'b0010, 0, 0, 0, "ilv r3"));
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 12, 65535, 0), 4'b0100, 0, 0, 0, "ilv r4"));
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 12, 65535, 0), 4'b0010, 0, 0, 0, "ilv r5"));
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 16, 65535, 0), 4'b0100, 0, 0, 0, "ilv r6"));
        vecs.push_back(mk(4'b0110, 4'b0000, pk(0, 16, 65535, 0), 4'b0010, 1, 10, 1, "ilv r7"));
        vecs.push_back(mk(4'b0100, 4'b0000, pk(0, 0, 65535, 0),  4'b0100, 1, 65535, 2, "ilv r8"));
        // truncation and wrap on channel 3: 1,2,2,2 -> 7>>2=1; then 6 -> 12>>2=3; 10 -> 20>>2=5
        vecs.push_back(mk(4'b1000, 4'b0000, pk(0, 0, 0, 1),  4'b1000, 0, 0, 0, "trunc s1"));
        vecs.push_back(mk(4'b1000, 4'b0000, pk(0, 0, 0, 2),  4'b1000, 0, 0, 0, "trunc s2"));
        vecs.push_back(mk(4'b1000, 4'b0000, pk(0, 0, 0, 2),  4'b1000, 0, 0, 0, "trunc s3"));
        vecs.push_back(mk(4'b1000, 4'b0000, pk(0, 0, 0, 2),  4'b1000, 1, 1, 3, "trunc s4"));
        vecs.push_back(mk(4'b1000, 4'b0000, pk(0, 0, 0, 6),  4'b1000, 1, 3, 3, "wrap s5"));
        vecs.push_back(mk(4'b1000, 4'b0000, pk(0, 0, 0, 10), 4'b1000, 1, 5, 3, "wrap s6"));

        // reset state, with all channels requesting
        rstn      = 1'b0;
        ch_valid  = 4'b1111;
        ch_clr    = 4'b0000;
        ch_sample = pk(1, 2, 3, 4);
        #12;
        chk("reset ch_ready", 32'(ch_ready), 32'h0);
        chk("reset avg", 32'(avg), 32'h0);
        chk("reset avg_ch", 32'(avg_ch), 32'h0);
        chk("reset avg_valid", 32'(avg_valid), 32'h0);
        @(negedge clk);
        ch_valid = 4'b0000;
        rstn     = 1'b1;

        foreach (vecs[i]) cycle(vecs[i]);

        // asynchronous reset while avg_valid is high
        #2;
        rstn     = 1'b0;
        ch_valid = 4'b1111;
        #1;
        chk("async avg_valid", 32'(avg_valid), 32'h0);
        chk("async avg", 32'(avg), 32'h0);
        chk("async avg_ch", 32'(avg_ch), 32'h0);
        chk("async ch_ready", 32'(ch_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("async hold avg_valid", 32'(avg_valid), 32'h0);
        @(negedge clk);
        ch_valid = 4'b0000;
        rstn     = 1'b1;

        // contention: all four channels with constant samples, fresh windows after reset
        for (int k = 1; k <= 20; k++) begin
            automatic int ch = (k - 1) % 4;
            cycle(mk(4'b1111, 4'b0000, pk(100, 200, 300, 400), 4'(1 << ch),
                     (k >= 13), (ch + 1) * 100, ch, $sformatf("contend k%0d", k)));
        end

        // clear collision on full channel 3 while channel 0 keeps working
        cycle(mk(4'b1001, 4'b1000, pk(100, 0, 0, 7), 4'b0001, 1, 100, 0, "clr collide"));
        cycle(mk(4'b1000, 4'b0000, pk(0, 0, 0, 7), 4'b1000, 0, 0, 0, "clr new1"));
        cycle(mk(4'b1000, 4'b0000, pk(0, 0, 0, 7), 4'b1000, 0, 0, 0, "clr new2"));
        cycle(mk(4'b1000, 4'b0000, pk(0, 0, 0, 7), 4'b1000, 0, 0, 0, "clr new3"));
        cycle(mk(4'b1000, 4'b0000, pk(0, 0, 0, 7), 4'b1000, 1, 7, 3, "clr new4"));

        @(negedge clk);
        ch_valid = 4'b0000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
